// File: rtl/unsigned_prod_acc_8x8.sv
// Accumulates VEC_LEN unsigned 16-bit products into one ACC_W-bit sum and holds it until it is taken downstream.
// Define ACC_SAT_EN to saturate the sum on overflow; it wraps by default. Result appears 1 cycle after the closing beat.
module unsigned_prod_acc_8x8 #(
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [15:0]      p_data,
  input  logic             p_last,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [ACC_W-1:0] s_data,
  output logic [7:0]       s_cnt,
  output logic             s_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       sync_q;
  logic             run, rdy, beat, close;
  logic [ACC_W:0]   sum;

  assign run  = sync_q[1];
  assign rdy  = run && (state_q != HOLD);
  assign beat = p_valid && rdy;

  // acc_q is zero in IDLE, so the first beat of a vector uses the same adder path.
  assign sum   = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, p_data};
  assign ovf_d = ovf_q | sum[ACC_W];
  assign cnt_d = cnt_q + 8'd1;
  assign close = p_last || (cnt_d == 8'(VEC_LEN));

`ifdef ACC_SAT_EN
  assign acc_d = ovf_d ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_d = sum[ACC_W-1:0];
`endif

  // Ready is forced high while reset is held, then waits for the synchronised release.
  assign p_ready = !rst_n || rdy;
  assign s_valid = (state_q == HOLD);
  assign s_data  = s_valid ? acc_q : '0;
  assign s_cnt   = s_valid ? cnt_q : 8'd0;
  assign s_ovf   = s_valid && ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= 8'd0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
      if (clr) begin
        state_q <= IDLE;
        acc_q   <= '0;
        cnt_q   <= 8'd0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE, ACC: begin
            if (beat) begin
              acc_q   <= acc_d;
              cnt_q   <= cnt_d;
              ovf_q   <= ovf_d;
              state_q <= close ? HOLD : ACC;
            end
          end
          HOLD: begin
            if (s_ready) begin
              state_q <= IDLE;
              acc_q   <= '0;
              cnt_q   <= 8'd0;
              ovf_q   <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
